// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: data-memory freeze with timeout abort, branch flush,
// load-use bubble insertion and saturating stall/flush statistics.
module hazard_stall_unit #(
    parameter int REG_W       = 6,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] Id_RegRs1,
    input  logic [REG_W-1:0] Id_RegRs2,
    input  logic             Id_useRs1,
    input  logic             Id_useRs2,
    input  logic             Ex_memRead,
    input  logic [REG_W-1:0] Ex_RegRd,
    input  logic             Ex_branchTaken,
    input  logic             Mem_memReq,
    input  logic             Mem_ready,
    input  logic             statsClr,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             idexWrite,
    output logic             exmemWrite,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             memErr,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] TIMEOUT_VAL = WC_W'(MEM_TIMEOUT);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_cnt_next;

    logic abort;
    logic freeze;
    logic load_use;
    logic branch_flush;
    logic lu_bubble;
    logic stall_inc;

    // The abort cycle releases the pipeline so the stuck access can retire as an error.
    assign abort        = (state == ST_WAIT) && (wait_cnt == TIMEOUT_VAL) && !Mem_ready;
    assign freeze       = Mem_memReq && !Mem_ready && !abort;
    assign load_use     = Ex_memRead && (Ex_RegRd != '0) &&
                          ((Id_useRs1 && (Ex_RegRd == Id_RegRs1)) ||
                           (Id_useRs2 && (Ex_RegRd == Id_RegRs2)));
    assign branch_flush = !freeze && Ex_branchTaken;
    assign lu_bubble    = !freeze && !Ex_branchTaken && load_use;
    assign stall_inc    = freeze || lu_bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            memErr   <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (abort) begin
                memErr <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            ST_RUN: begin
                if (freeze) begin
                    state_next    = ST_WAIT;
                    wait_cnt_next = WC_W'(1);
                end
            end
            ST_WAIT: begin
                if (abort || !freeze) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt + WC_W'(1);
                end
            end
            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Priority: memory freeze, then taken-branch flush, then load-use bubble.
    always_comb begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        idexWrite  = 1'b1;
        exmemWrite = 1'b1;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        if (freeze) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
        end else if (Ex_branchTaken) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (load_use) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexFlush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else if (statsClr) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            if (stall_inc && (stallCycles != '1)) begin
                stallCycles <= stallCycles + CNT_W'(1);
            end
            if (branch_flush && (flushCount != '1)) begin
                flushCount <= flushCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit; a second 4-bit-counter instance exercises saturation.
module tb_hazard_stall_unit;

    logic       clk;
    logic       rst_n;
    logic [5:0] Id_RegRs1, Id_RegRs2, Ex_RegRd;
    logic       Id_useRs1, Id_useRs2, Ex_memRead, Ex_branchTaken;
    logic       Mem_memReq, Mem_ready, statsClr;

    logic        pcWrite, ifidWrite, idexWrite, exmemWrite, ifidFlush, idexFlush, memErr;
    logic [15:0] stallCycles, flushCount;

    logic       s_pc, s_ifid, s_idex, s_exmem, s_ifidf, s_idexf, s_err;
    logic [3:0] s_stall, s_flush;

    logic [5:0] ctl;
    assign ctl = {pcWrite, ifidWrite, idexWrite, exmemWrite, ifidFlush, idexFlush};

    localparam logic [5:0] CTL_NORM   = 6'b111100;
    localparam logic [5:0] CTL_FREEZE = 6'b000000;
    localparam logic [5:0] CTL_BRANCH = 6'b111111;
    localparam logic [5:0] CTL_LU     = 6'b001101;

    int pass_count  = 0;
    int check_count = 0;

    hazard_stall_unit #(.REG_W(6), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .Id_RegRs1(Id_RegRs1), .Id_RegRs2(Id_RegRs2),
        .Id_useRs1(Id_useRs1), .Id_useRs2(Id_useRs2),
        .Ex_memRead(Ex_memRead), .Ex_RegRd(Ex_RegRd), .Ex_branchTaken(Ex_branchTaken),
        .Mem_memReq(Mem_memReq), .Mem_ready(Mem_ready), .statsClr(statsClr),
        .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexWrite(idexWrite),
        .exmemWrite(exmemWrite), .ifidFlush(ifidFlush), .idexFlush(idexFlush),
        .memErr(memErr), .stallCycles(stallCycles), .flushCount(flushCount)
    );

    hazard_stall_unit #(.REG_W(6), .MEM_TIMEOUT(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .Id_RegRs1(Id_RegRs1), .Id_RegRs2(Id_RegRs2),
        .Id_useRs1(Id_useRs1), .Id_useRs2(Id_useRs2),
        .Ex_memRead(Ex_memRead), .Ex_RegRd(Ex_RegRd), .Ex_branchTaken(Ex_branchTaken),
        .Mem_memReq(Mem_memReq), .Mem_ready(Mem_ready), .statsClr(statsClr),
        .pcWrite(s_pc), .ifidWrite(s_ifid), .idexWrite(s_idex),
        .exmemWrite(s_exmem), .ifidFlush(s_ifidf), .idexFlush(s_idexf),
        .memErr(s_err), .stallCycles(s_stall), .flushCount(s_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        Id_RegRs1 = 6'd0; Id_RegRs2 = 6'd0; Id_useRs1 = 1'b0; Id_useRs2 = 1'b0;
        Ex_memRead = 1'b0; Ex_RegRd = 6'd0; Ex_branchTaken = 1'b0;
        Mem_memReq = 1'b0; Mem_ready = 1'b0; statsClr = 1'b0;
    endtask

    task automatic set_load_use(input logic [5:0] rd, input logic [5:0] rs1, input logic [5:0] rs2,
                                input logic u1, input logic u2);
        Ex_memRead = 1'b1; Ex_RegRd = rd;
        Id_RegRs1 = rs1; Id_RegRs2 = rs2; Id_useRs1 = u1; Id_useRs2 = u2;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        #13;
        check_count++;
        if (ctl !== CTL_NORM) $display("[TB] FAIL reset_ctl: got %b expected %b", ctl, CTL_NORM);
        else pass_count++;
        check_count++;
        if (memErr !== 1'b0 || stallCycles !== 16'd0 || flushCount !== 16'd0)
            $display("[TB] FAIL reset_regs: got err=%b stall=%0d flush=%0d expected 0/0/0",
                     memErr, stallCycles, flushCount);
        else pass_count++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_use();
        set_load_use(6'd5, 6'd3, 6'd5, 1'b1, 1'b1);
        #1;
        check_count++;
        if (ctl !== CTL_LU) $display("[TB] FAIL lu_rs2_ctl: got %b expected %b", ctl, CTL_LU);
        else pass_count++;
        step();
        set_idle();
        #1;
        check_count++;
        if (stallCycles !== 16'd1 || ctl !== CTL_NORM)
            $display("[TB] FAIL lu_rs2_after: got stall=%0d ctl=%b expected 1/%b", stallCycles, ctl, CTL_NORM);
        else pass_count++;
        set_load_use(6'd7, 6'd7, 6'd2, 1'b1, 1'b0);
        #1;
        check_count++;
        if (ctl !== CTL_LU) $display("[TB] FAIL lu_rs1_ctl: got %b expected %b", ctl, CTL_LU);
        else pass_count++;
        step();
        set_idle();
        #1;
        check_count++;
        if (stallCycles !== 16'd2) $display("[TB] FAIL lu_rs1_count: got %0d expected 2", stallCycles);
        else pass_count++;
    endtask

    task automatic test_no_stall();
        set_load_use(6'd0, 6'd0, 6'd0, 1'b1, 1'b1);
        #1;
        check_count++;
        if (ctl !== CTL_NORM) $display("[TB] FAIL nostall_rd0: got %b expected %b", ctl, CTL_NORM);
        else pass_count++;
        step();
        set_load_use(6'd5, 6'd1, 6'd5, 1'b0, 1'b0);
        #1;
        check_count++;
        if (ctl !== CTL_NORM) $display("[TB] FAIL nostall_nouse: got %b expected %b", ctl, CTL_NORM);
        else pass_count++;
        step();
        set_idle();
        #1;
        check_count++;
        if (stallCycles !== 16'd2) $display("[TB] FAIL nostall_count: got %0d expected 2", stallCycles);
        else pass_count++;
    endtask

    task automatic test_mem_wait();
        Mem_memReq = 1'b1; Mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_count++;
            if (ctl !== CTL_FREEZE)
                $display("[TB] FAIL memwait_freeze%0d: got %b expected %b", i, ctl, CTL_FREEZE);
            else pass_count++;
            step();
        end
        Mem_ready = 1'b1;
        #1;
        check_count++;
        if (ctl !== CTL_NORM) $display("[TB] FAIL memwait_ready: got %b expected %b", ctl, CTL_NORM);
        else pass_count++;
        step();
        set_idle();
        #1;
        check_count++;
        if (stallCycles !== 16'd5 || memErr !== 1'b0 || dut.wait_cnt !== '0)
            $display("[TB] FAIL memwait_after: got stall=%0d err=%b wcnt=%0d expected 5/0/0",
                     stallCycles, memErr, dut.wait_cnt);
        else pass_count++;
    endtask

    task automatic test_timeout();
        Mem_memReq = 1'b1; Mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_count++;
            if (ctl !== CTL_FREEZE)
                $display("[TB] FAIL timeout_freeze%0d: got %b expected %b", i, ctl, CTL_FREEZE);
            else pass_count++;
            step();
        end
        #1;
        check_count++;
        if (ctl !== CTL_NORM || memErr !== 1'b0)
            $display("[TB] FAIL timeout_abort: got ctl=%b err=%b expected %b/0", ctl, memErr, CTL_NORM);
        else pass_count++;
        step();
        set_idle();
        #1;
        check_count++;
        if (memErr !== 1'b1 || stallCycles !== 16'd9 || dut.wait_cnt !== '0)
            $display("[TB] FAIL timeout_after: got err=%b stall=%0d wcnt=%0d expected 1/9/0",
                     memErr, stallCycles, dut.wait_cnt);
        else pass_count++;
        repeat (3) step();
        check_count++;
        if (memErr !== 1'b1) $display("[TB] FAIL timeout_sticky: got %b expected 1", memErr);
        else pass_count++;
    endtask

    task automatic test_branch();
        set_load_use(6'd5, 6'd3, 6'd5, 1'b1, 1'b1);
        Ex_branchTaken = 1'b1;
        #1;
        check_count++;
        if (ctl !== CTL_BRANCH) $display("[TB] FAIL branch_ctl: got %b expected %b", ctl, CTL_BRANCH);
        else pass_count++;
        step();
        Mem_memReq = 1'b1; Mem_ready = 1'b0;
        #1;
        check_count++;
        if (flushCount !== 16'd1 || stallCycles !== 16'd9)
            $display("[TB] FAIL branch_count: got flush=%0d stall=%0d expected 1/9", flushCount, stallCycles);
        else pass_count++;
        check_count++;
        if (ctl !== CTL_FREEZE) $display("[TB] FAIL branch_frozen: got %b expected %b", ctl, CTL_FREEZE);
        else pass_count++;
        step();
        set_idle();
        step();
        check_count++;
        if (flushCount !== 16'd1 || stallCycles !== 16'd10 || dut.wait_cnt !== '0)
            $display("[TB] FAIL branch_after: got flush=%0d stall=%0d wcnt=%0d expected 1/10/0",
                     flushCount, stallCycles, dut.wait_cnt);
        else pass_count++;
    endtask

    task automatic test_reset_mid_wait();
        Mem_memReq = 1'b1; Mem_ready = 1'b0;
        step();
        step();
        Mem_memReq = 1'b0;
        rst_n = 1'b0;
        #1;
        check_count++;
        if (dut.wait_cnt !== '0 || memErr !== 1'b0 || stallCycles !== 16'd0)
            $display("[TB] FAIL rstwait_now: got wcnt=%0d err=%b stall=%0d expected 0/0/0",
                     dut.wait_cnt, memErr, stallCycles);
        else pass_count++;
        step();
        rst_n = 1'b1;
        repeat (6) step();
        check_count++;
        if (memErr !== 1'b0 || ctl !== CTL_NORM)
            $display("[TB] FAIL rstwait_after: got err=%b ctl=%b expected 0/%b", memErr, ctl, CTL_NORM);
        else pass_count++;
    endtask

    task automatic test_saturation();
        set_load_use(6'd5, 6'd3, 6'd5, 1'b1, 1'b1);
        repeat (20) step();
        check_count++;
        if (s_stall !== 4'hF || stallCycles !== 16'd20)
            $display("[TB] FAIL sat_hold: got small=%0d wide=%0d expected 15/20", s_stall, stallCycles);
        else pass_count++;
        statsClr = 1'b1;
        step();
        statsClr = 1'b0;
        set_idle();
        #1;
        check_count++;
        if (s_stall !== 4'h0 || stallCycles !== 16'd0 || flushCount !== 16'd0)
            $display("[TB] FAIL sat_clear: got small=%0d wide=%0d flush=%0d expected 0/0/0",
                     s_stall, stallCycles, flushCount);
        else pass_count++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_mem_wait();
        test_timeout();
        test_branch();
        test_reset_mid_wait();
        test_saturation();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
